// File: rtl/prog_cache_pkg.sv
// Shared definitions for the program cache: geometry, FSM encoding and
// address field slicing helpers.
package prog_cache_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 3;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_REPLAY = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/prog_cache_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register is cleared by reset so the cache output starts at zero;
// the array itself is never reset.
module p_cache_ram #(
    parameter int WIDTH   = 16,
    parameter int DEPTH_W = 9
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem_r [2**DEPTH_W];
    logic [WIDTH-1:0] rdata_r;

    // Write port: store one word when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: registered read, returns the value held before any same-edge write.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rdata_r <= {WIDTH{1'b0}};
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/prog_cache.sv
// Direct-mapped read-only instruction cache. Every edge looks up the fetch
// address; a miss triggers a line refill by burst read, then a one-cycle
// replay so the RAMs are re-read with the PC's current address.
module prog_cache
    import prog_cache_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A,
    input  logic              flush,
    output logic [DATA_W-1:0] I,
    output logic              p_cache_miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t                 state_r;
    state_t                 state_s;
    logic [TAG_W-1:0]       lk_tag_r;
    logic [INDEX_W-1:0]     lk_index_r;
    logic                   lookup_vld_r;
    logic [2**INDEX_W-1:0]  valid_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [OFFSET_W-1:0]    beat_cnt_r;
    logic                   flush_pend_r;

    logic [TAG_W-1:0]       tag_q_s;
    logic                   hit_s;
    logic                   miss_s;
    logic                   fill_we_s;
    logic                   last_beat_s;
    logic [INDEX_W-1:0]     fill_index_s;
    logic [TAG_W-1:0]       fill_tag_s;

    assign fill_index_s = addr_index(mem_addr_r);
    assign fill_tag_s   = addr_tag(mem_addr_r);

    p_cache_ram #(
        .WIDTH   (DATA_W),
        .DEPTH_W (INDEX_W + OFFSET_W)
    ) u_data_ram (
        .clk   (clk),
        .RST   (RST),
        .we    (fill_we_s),
        .waddr ({fill_index_s, beat_cnt_r}),
        .wdata (mem_rdata),
        .raddr ({addr_index(A), addr_offset(A)}),
        .rdata (I)
    );

    p_cache_ram #(
        .WIDTH   (TAG_W),
        .DEPTH_W (INDEX_W)
    ) u_tag_ram (
        .clk   (clk),
        .RST   (RST),
        .we    (last_beat_s),
        .waddr (fill_index_s),
        .wdata (fill_tag_s),
        .raddr (addr_index(A)),
        .rdata (tag_q_s)
    );

    // Hit detection for the address looked up at the previous edge.
    always_comb begin
        hit_s = lookup_vld_r & valid_r[lk_index_r] & (tag_q_s == lk_tag_r);
    end

    // Next-state, miss flag and refill write strobes.
    always_comb begin
        state_s     = state_r;
        miss_s      = 1'b1;
        fill_we_s   = 1'b0;
        last_beat_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                miss_s = lookup_vld_r & ~hit_s;
                if (miss_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_FILL: begin
                if (mem_rvalid) begin
                    fill_we_s = 1'b1;
                    if (beat_cnt_r == {OFFSET_W{1'b1}}) begin
                        last_beat_s = 1'b1;
                        state_s     = ST_REPLAY;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_REPLAY: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                miss_s  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Lookup pipeline: capture the fetch address fields alongside the RAM read.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            lk_tag_r     <= {TAG_W{1'b0}};
            lk_index_r   <= {INDEX_W{1'b0}};
            lookup_vld_r <= 1'b0;
        end else begin
            lk_tag_r     <= addr_tag(A);
            lk_index_r   <= addr_index(A);
            lookup_vld_r <= 1'b1;
        end
    end

    // Latch the line-aligned burst address when a miss is detected.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            mem_addr_r <= {ADDR_W{1'b0}};
        end else if ((state_r == ST_IDLE) && miss_s) begin
            mem_addr_r <= {lk_tag_r, lk_index_r, {OFFSET_W{1'b0}}};
        end else begin
            mem_addr_r <= mem_addr_r;
        end
    end

    // Beat counter: restarts while requesting, advances on each accepted beat.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            beat_cnt_r <= {OFFSET_W{1'b0}};
        end else if (state_r == ST_REQ) begin
            beat_cnt_r <= {OFFSET_W{1'b0}};
        end else if (fill_we_s) begin
            beat_cnt_r <= beat_cnt_r + {{(OFFSET_W-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Remember a flush seen while a refill is in flight so the line stays invalid.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            flush_pend_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            flush_pend_r <= 1'b0;
        end else if (flush && ((state_r == ST_REQ) || (state_r == ST_FILL))) begin
            flush_pend_r <= 1'b1;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end

    // Valid bits: flush wins, otherwise a clean refill marks its line valid.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            valid_r <= {(2**INDEX_W){1'b0}};
        end else if (flush) begin
            valid_r <= {(2**INDEX_W){1'b0}};
        end else if (last_beat_s && !flush_pend_r) begin
            valid_r[fill_index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign p_cache_miss = miss_s;
    assign mem_req      = (state_r == ST_REQ);
    assign mem_addr     = mem_addr_r;

endmodule

// File: tb/tb_prog_cache.sv
// Directed self-checking bench for prog_cache with a hand-driven SDRAM side.
module tb_prog_cache;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] A;
    logic        flush;
    logic [15:0] I;
    logic        p_cache_miss;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    prog_cache dut (
        .clk          (clk),
        .RST          (RST),
        .A            (A),
        .flush        (flush),
        .I            (I),
        .p_cache_miss (p_cache_miss),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one refill: wait for mem_req, optionally delay ack, stream 8 beats
    // (base+k), optionally pulse flush with beat flush_beat. Returns in REPLAY.
    task automatic refill(input logic [15:0] base, input int ack_delay, input int flush_beat,
                          output logic got_req, output logic [15:0] req_addr, output logic stable);
        got_req  = 1'b0;
        stable   = 1'b1;
        req_addr = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            if (!got_req) begin
                if (mem_req === 1'b1) got_req = 1'b1;
                else tick();
            end
        end
        if (got_req) begin
            req_addr = mem_addr;
            for (int d = 0; d < ack_delay; d++) begin
                tick();
                if (mem_req !== 1'b1 || mem_addr !== req_addr || p_cache_miss !== 1'b1) stable = 1'b0;
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            if (p_cache_miss !== 1'b1) stable = 1'b0;
            for (int k = 0; k < 8; k++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = base + 16'(k);
                flush      = (k == flush_beat);
                tick();
                flush = 1'b0;
                if (p_cache_miss !== 1'b1) stable = 1'b0;
            end
            mem_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; A = 16'h0000; flush = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
        #1;
        vectors++; if (I !== 16'h0000) begin miscompares++; $display("FAIL reset_I: got %h want %h", I, 16'h0000); end
        vectors++; if (p_cache_miss !== 1'b0) begin miscompares++; $display("FAIL reset_miss: got %b want 0", p_cache_miss); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", mem_req); end
        vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_cold_miss();
        logic got; logic [15:0] ra; logic st;
        A = 16'h0000;
        tick();
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL cold_miss_flag: got %b want 1", p_cache_miss); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL cold_req_early: got %b want 0", mem_req); end
        refill(16'h1000, 0, -1, got, ra, st);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL cold_req_seen: got %b want 1", got); end
        vectors++; if (ra !== 16'h0000) begin miscompares++; $display("FAIL cold_mem_addr: got %h want 0000", ra); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL cold_miss_held: got %b want 1", st); end
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL cold_replay_miss: got %b want 1", p_cache_miss); end
        tick();
        vectors++; if (p_cache_miss !== 1'b0) begin miscompares++; $display("FAIL cold_miss_fall: got %b want 0", p_cache_miss); end
        vectors++; if (I !== 16'h1000) begin miscompares++; $display("FAIL cold_I: got %h want 1000", I); end
    endtask

    task automatic test_hits();
        for (int k = 1; k < 8; k++) begin
            A = 16'(k);
            tick();
            vectors++; if (I !== 16'h1000 + 16'(k)) begin miscompares++; $display("FAIL hit_I[%0d]: got %h want %h", k, I, 16'h1000 + 16'(k)); end
            vectors++; if (p_cache_miss !== 1'b0) begin miscompares++; $display("FAIL hit_miss[%0d]: got %b want 0", k, p_cache_miss); end
            vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL hit_req[%0d]: got %b want 0", k, mem_req); end
        end
    endtask

    task automatic test_conflict();
        logic got; logic [15:0] ra; logic st;
        A = 16'h0200;
        tick();
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL conf_miss1: got %b want 1", p_cache_miss); end
        refill(16'h2000, 0, -1, got, ra, st);
        vectors++; if (ra !== 16'h0200) begin miscompares++; $display("FAIL conf_addr1: got %h want 0200", ra); end
        tick();
        vectors++; if (I !== 16'h2000) begin miscompares++; $display("FAIL conf_I1: got %h want 2000", I); end
        vectors++; if (p_cache_miss !== 1'b0) begin miscompares++; $display("FAIL conf_hit1: got %b want 0", p_cache_miss); end
        A = 16'h0000;
        tick();
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL conf_miss2: got %b want 1", p_cache_miss); end
        refill(16'h1000, 0, -1, got, ra, st);
        vectors++; if (ra !== 16'h0000) begin miscompares++; $display("FAIL conf_addr2: got %h want 0000", ra); end
        tick();
        vectors++; if (I !== 16'h1000) begin miscompares++; $display("FAIL conf_I2: got %h want 1000", I); end
    endtask

    task automatic test_slow_ack();
        logic got; logic [15:0] ra; logic st;
        A = 16'h0010;
        tick();
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL slow_miss: got %b want 1", p_cache_miss); end
        refill(16'h3000, 5, -1, got, ra, st);
        vectors++; if (ra !== 16'h0010) begin miscompares++; $display("FAIL slow_addr: got %h want 0010", ra); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL slow_stable: got %b want 1", st); end
        tick();
        vectors++; if (I !== 16'h3000) begin miscompares++; $display("FAIL slow_I: got %h want 3000", I); end
        vectors++; if (p_cache_miss !== 1'b0) begin miscompares++; $display("FAIL slow_hit: got %b want 0", p_cache_miss); end
    endtask

    task automatic test_flush_mid_fill();
        logic got; logic [15:0] ra; logic st;
        A = 16'h0028;
        tick();
        refill(16'h4000, 0, 4, got, ra, st);
        vectors++; if (ra !== 16'h0028) begin miscompares++; $display("FAIL flush_addr1: got %h want 0028", ra); end
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL flush_replay: got %b want 1", p_cache_miss); end
        tick();
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL flush_remiss: got %b want 1", p_cache_miss); end
        refill(16'h4000, 0, -1, got, ra, st);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL flush_req2: got %b want 1", got); end
        vectors++; if (ra !== 16'h0028) begin miscompares++; $display("FAIL flush_addr2: got %h want 0028", ra); end
        tick();
        vectors++; if (I !== 16'h4000) begin miscompares++; $display("FAIL flush_I: got %h want 4000", I); end
        vectors++; if (p_cache_miss !== 1'b0) begin miscompares++; $display("FAIL flush_hit: got %b want 0", p_cache_miss); end
        A = 16'h0000;
        tick();
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL flush_line0_gone: got %b want 1", p_cache_miss); end
    endtask

    task automatic test_rst_mid_fill();
        logic got; logic [15:0] ra; logic st;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!got) begin
                if (mem_req === 1'b1) got = 1'b1;
                else tick();
            end
        end
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rst_req_seen: got %b want 1", got); end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 16'hAAA0 + 16'(k); tick();
        end
        RST = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        vectors++; if (I !== 16'h0000) begin miscompares++; $display("FAIL rst_I: got %h want 0000", I); end
        vectors++; if (p_cache_miss !== 1'b0) begin miscompares++; $display("FAIL rst_miss: got %b want 0", p_cache_miss); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", mem_req); end
        tick(); tick();
        RST = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        vectors++; if (p_cache_miss !== 1'b1) begin miscompares++; $display("FAIL rst_line_miss: got %b want 1", p_cache_miss); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req_idle: got %b want 0", mem_req); end
        refill(16'h1000, 0, -1, got, ra, st);
        vectors++; if (ra !== 16'h0000) begin miscompares++; $display("FAIL rst_refill_addr: got %h want 0000", ra); end
        tick();
        vectors++; if (I !== 16'h1000) begin miscompares++; $display("FAIL rst_refill_I: got %h want 1000", I); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_slow_ack();
        test_flush_mid_fill();
        test_rst_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
